// File: rtl/arb_pkg.sv
// Shared types for the 4-to-1 round-robin arbiter: FSM states, requester index
// type, one-hot decode constants and the round-robin search helper.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    typedef logic [1:0] arb_idx_t;

    localparam logic [3:0] ONEHOT_0 = 4'b0001;
    localparam logic [3:0] ONEHOT_1 = 4'b0010;
    localparam logic [3:0] ONEHOT_2 = 4'b0100;
    localparam logic [3:0] ONEHOT_3 = 4'b1000;

    function automatic logic [3:0] onehot(input arb_idx_t idx);
        case (idx)
            2'd0:    onehot = ONEHOT_0;
            2'd1:    onehot = ONEHOT_1;
            2'd2:    onehot = ONEHOT_2;
            default: onehot = ONEHOT_3;
        endcase
    endfunction

    // Walk offsets from farthest to nearest so the closest set bit at or after
    // ptr is the last assignment and wins.
    function automatic arb_idx_t rr_pick(input logic [3:0] req, input arb_idx_t ptr);
        arb_idx_t idx;
        rr_pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + arb_idx_t'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/mux_4x1_32bit.sv
// Plain 4-to-1 selector for 32-bit words.
module mux_4x1_32bit (
    input  logic [31:0] I0,
    input  logic [31:0] I1,
    input  logic [31:0] I2,
    input  logic [31:0] I3,
    input  logic [1:0]  s,
    output logic [31:0] Y
);

    always_comb begin
        case (s)
            2'd0:    Y = I0;
            2'd1:    Y = I1;
            2'd2:    Y = I2;
            default: Y = I3;
        endcase
    end

endmodule

// File: rtl/mux_arbiter_4x1_32bit.sv
// Round-robin 4-requester arbiter with a one-word registered output buffer.
// Define ARB_BURST_LOCK_EN to let a locked winner keep the grant up to MAX_HOLD transfers.
//
//   state | meaning
//   IDLE  | Y empty, y_valid low; any request is captured on the next edge
//   HOLD  | Y full, y_valid high; refilled in the same cycle it is taken
import arb_pkg::*;

module mux_arbiter_4x1_32bit #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [3:0]  lock,
    input  logic [31:0] I0,
    input  logic [31:0] I1,
    input  logic [31:0] I2,
    input  logic [31:0] I3,
    output logic [3:0]  ack,
    output logic [31:0] Y,
    output logic [1:0]  s,
    output logic        y_valid,
    input  logic        y_ready
);

    arb_state_e  state_q, state_d;
    logic [31:0] y_q, y_d;
    arb_idx_t    s_q, s_d;
    arb_idx_t    ptr_q, ptr_d;
    logic [3:0]  ack_q, ack_d;
    arb_idx_t    win;
    logic [31:0] mux_y;
    logic        capture;

    assign win = rr_pick(req, ptr_q);

    mux_4x1_32bit u_mux (
        .I0 (I0),
        .I1 (I1),
        .I2 (I2),
        .I3 (I3),
        .s  (win),
        .Y  (mux_y)
    );

    assign capture = (req != 4'b0000) && ((state_q == IDLE) || y_ready);

`ifdef ARB_BURST_LOCK_EN
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] hold_q, hold_d;
`else
    // lock and MAX_HOLD only matter when burst lock is built in.
    logic unused_cfg;
    assign unused_cfg = (^lock) ^ (MAX_HOLD > 0);
`endif

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        ack_d   = 4'b0000;
`ifdef ARB_BURST_LOCK_EN
        hold_d  = hold_q;
`endif
        if (capture) begin
            state_d = HOLD;
            y_d     = mux_y;
            s_d     = win;
            ack_d   = onehot(win);
`ifdef ARB_BURST_LOCK_EN
            if (lock[win] && (int'(hold_q) < MAX_HOLD - 1)) begin
                ptr_d  = win;
                hold_d = hold_q + 1'b1;
            end else begin
                ptr_d  = win + 2'd1;
                hold_d = '0;
            end
`else
            ptr_d   = win + 2'd1;
`endif
        end else if ((state_q == HOLD) && y_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            s_q     <= '0;
            ptr_q   <= '0;
            ack_q   <= '0;
`ifdef ARB_BURST_LOCK_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
`ifdef ARB_BURST_LOCK_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign Y       = y_q;
    assign s       = s_q;
    assign ack     = ack_q;
    assign y_valid = (state_q == HOLD);

endmodule

// File: doc/mux_arbiter_4x1_32bit.md
MUX_ARBITER_4X1_32BIT -- requirements
Module: mux_arbiter_4x1_32bit

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive transfers one locked requester may keep the grant.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port req, input, 4: per-requester request; bit i qualifies Ii.
REQ-005 Port lock, input, 4: per-requester burst-lock hint; used only with ARB_BURST_LOCK_EN.
REQ-006 Ports I0, I1, I2, I3, input, 32 each: requester data; must be stable while the matching req is high.
REQ-007 Port ack, output, 4: one-hot, one-cycle pulse; the matching requester's data was captured.
REQ-008 Port Y, output, 32: registered output data.
REQ-009 Port s, output, 2: index of the requester whose data is in Y.
REQ-010 Port y_valid, output, 1: Y holds an untaken word.
REQ-011 Port y_ready, input, 1: consumer accepts Y when y_valid and y_ready are both high.

Function
REQ-012 States: IDLE (Y empty) and HOLD (Y full); no other states.
REQ-013 IDLE with any req high: pick a winner, capture its data into Y, set s, pulse ack[winner], go to HOLD; latency from req to y_valid is 1 cycle.
REQ-014 IDLE with req == 0: stay in IDLE; Y and s keep their values.
REQ-015 HOLD with y_ready low: hold Y, s and y_valid; no ack; ignore changes on req.
REQ-016 HOLD with y_ready high and req != 0: in the same cycle, capture the next winner and pulse its ack; stay in HOLD; sustains one word per cycle.
REQ-017 HOLD with y_ready high and req == 0: go to IDLE; y_valid drops on the next edge.
REQ-018 Winner is round-robin: search starts at index ptr and goes ptr, ptr+1, ... mod 4; first req bit found wins.
REQ-019 After each capture, ptr becomes (winner+1) mod 4, except as REQ-024 says.
REQ-020 A requester that drops req before its ack is not captured; no error is flagged.
REQ-021 ack never has more than one bit set, and never pulses twice for one captured word.

Reset
REQ-022 rst_n low forces, asynchronously: state IDLE, Y = 0, s = 0, y_valid = 0, ack = 0, ptr = 0, hold count = 0.
REQ-023 Reset during HOLD discards the word in Y; after rst_n releases, the first capture starts the search at index 0.

Configuration
REQ-024 With ARB_BURST_LOCK_EN defined:
- If lock[winner] is high at capture and hold count < MAX_HOLD-1, ptr stays at winner and hold count increments.
- Otherwise ptr advances per REQ-019 and hold count clears to 0.
REQ-025 Without ARB_BURST_LOCK_EN: lock is ignored, no hold counter exists, and arbitration is pure round-robin.

Structure
REQ-026 Shared package arb_pkg holds the state enum (IDLE, HOLD), the 2-bit index type and the one-hot decode constants.
REQ-027 The data select is one instance of the existing mux_4x1_32bit, driven by the next-winner index; no other sub-modules.

Verification
REQ-028 All four req high, y_ready held at 1 -> captures in order 0,1,2,3,0; one ack per cycle; Y = I0..I3 values 0xA0,0xA1,0xA2,0xA3.
REQ-029 req = 4'b0100, y_ready = 0 for 5 cycles -> Y = I2 and s = 2 stable; single ack[2] pulse; y_valid high throughout.
REQ-030 rst_n pulsed low mid-HOLD with Y = 0xDEADBEEF -> y_valid = 0 and Y = 0 immediately, without a clock edge; next capture searches from index 0.
REQ-031 ARB_BURST_LOCK_EN, MAX_HOLD = 8, req = 4'b0011, lock[0] = 1, y_ready = 1 -> 8 captures from requester 0, then 1 from requester 1, then requester 0 again.
REQ-032 Same stimulus without ARB_BURST_LOCK_EN -> captures alternate 0,1,0,1.
REQ-033 req pulses to 4'b1000 for one cycle while in HOLD with y_ready = 0 -> no ack[3]; Y unchanged.
